sensor_conditioner: RTL and testbench

//   Front-end stage feeding the irrigation controller. Synchronises the seven raw switch/sensor inputs
//   (water level high/middle/low, soil humidity, air humidity, temperature, display selector) to clk.

---
 rtl/sensor_conditioner.sv | 90 +++++++++
 tb/tb_sensor_conditioner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: front-end for the irrigation controller.
// Synchronises the raw switch/sensor inputs to clk, debounces each bit
// independently, pulses a per-bit change flag when a clean level toggles,
// and reports when no debounce count is in progress anywhere.
// Bit map (N_IN=7): [0] high, [1] middle, [2] low, [3] umidadeDoSolo,
// [4] umidadeDoAr, [5] temperatura, [6] seletor.
module sensor_conditioner #(
  parameter int N_IN            = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean_out,
  output logic [N_IN-1:0] changed,
  output logic            settled
);

  // Terminal count: a bit is accepted on the edge where its counter
  // already holds this value and the synchronised input still differs.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  logic [CNT_W-1:0] cnt [N_IN];
  logic [1:0]       fill;
  logic             all_idle;

  // Two-flop synchroniser per bit; only s2 is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Per-bit debouncer: count consecutive disagreement cycles, accept the
  // new level at terminal count and pulse changed for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
      clean_out <= '0;
      changed   <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        changed[i] <= 1'b0;
        if (s2[i] == clean_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= CNT_MAX) begin
          clean_out[i] <= s2[i];
          cnt[i]       <= '0;
          changed[i]   <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Idle when every counter is at zero and no bit disagrees with its clean level.
  always_comb begin
    all_idle = (s2 == clean_out);
    for (int i = 0; i < N_IN; i++) begin
      if (cnt[i] != '0) begin
        all_idle = 1'b0;
      end
    end
  end

  // settled stays low while the sync chain refills after reset, then
  // tracks the registered idle condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill    <= 2'd0;
      settled <= 1'b0;
    end else if (fill != 2'd2) begin
      fill    <= fill + 2'd1;
      settled <= 1'b0;
    end else begin
      settled <= all_idle;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner with DEBOUNCE_CYCLES=4.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a period away from the active rising edge.
module tb_sensor_conditioner;

  logic       clk;
  logic       rst;
  logic [6:0] raw_in;
  logic [6:0] clean_out;
  logic [6:0] changed;
  logic       settled;

  int n_cmp;
  int n_bad;

  // Expected change events: {changed mask, clean_out after the change}.
  logic [13:0] exp_q[$];

  typedef struct {
    logic [6:0]  raw;
    int          hold;
    logic [6:0]  exp_clean;
    logic [6:0]  exp_chg;
    logic        exp_settled;
    logic        push;
    logic [13:0] push_val;
  } vec_t;

  vec_t vecs [15];

  sensor_conditioner #(
    .N_IN(7),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .clean_out(clean_out),
    .changed(changed),
    .settled(settled)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every change pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && changed != 7'h00) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_pulse: got chg=%0h clean=%0h expected none", changed, clean_out);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if ({changed, clean_out} !== e) begin
          n_bad++;
          $display("FAIL sb_event: got chg=%0h clean=%0h expected chg=%0h clean=%0h",
                   changed, clean_out, e[13:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    raw_in = 7'h00;

    //            raw    hold clean  chg    set  push  {chg, clean}
    vecs[0]  = '{7'h00, 4,   7'h00, 7'h00, 1'b1, 1'b0, {7'h00, 7'h00}};
    vecs[1]  = '{7'h01, 5,   7'h00, 7'h00, 1'b0, 1'b1, {7'h01, 7'h01}};
    vecs[2]  = '{7'h01, 1,   7'h01, 7'h01, 1'b0, 1'b0, {7'h00, 7'h00}};
    vecs[3]  = '{7'h01, 2,   7'h01, 7'h00, 1'b1, 1'b0, {7'h00, 7'h00}};
    vecs[4]  = '{7'h09, 3,   7'h01, 7'h00, 1'b0, 1'b0, {7'h00, 7'h00}};
    vecs[5]  = '{7'h01, 8,   7'h01, 7'h00, 1'b1, 1'b0, {7'h00, 7'h00}};
    vecs[6]  = '{7'h11, 4,   7'h01, 7'h00, 1'b0, 1'b1, {7'h10, 7'h11}};
    vecs[7]  = '{7'h01, 2,   7'h11, 7'h10, 1'b0, 1'b0, {7'h00, 7'h00}};
    vecs[8]  = '{7'h01, 4,   7'h01, 7'h10, 1'b0, 1'b1, {7'h10, 7'h01}};
    vecs[9]  = '{7'h01, 2,   7'h01, 7'h00, 1'b1, 1'b0, {7'h00, 7'h00}};
    vecs[10] = '{7'h00, 8,   7'h00, 7'h00, 1'b1, 1'b1, {7'h01, 7'h00}};
    vecs[11] = '{7'h45, 5,   7'h00, 7'h00, 1'b0, 1'b1, {7'h45, 7'h45}};
    vecs[12] = '{7'h45, 1,   7'h45, 7'h45, 1'b0, 1'b0, {7'h00, 7'h00}};
    vecs[13] = '{7'h45, 1,   7'h45, 7'h00, 1'b1, 1'b0, {7'h00, 7'h00}};
    vecs[14] = '{7'h00, 10,  7'h00, 7'h00, 1'b1, 1'b1, {7'h45, 7'h00}};

    // Power-on reset.
    step(3);
    check("por_clean", 32'(clean_out), 32'h0);
    check("por_changed", 32'(changed), 32'h0);
    check("por_settled", 32'(settled), 32'h0);
    rst = 1'b0;

    // Table: steps, glitches, 4-cycle acceptance boundary, simultaneous bits.
    for (int k = 0; k < 15; k++) begin
      raw_in = vecs[k].raw;
      if (vecs[k].push) exp_q.push_back(vecs[k].push_val);
      step(vecs[k].hold);
      check($sformatf("vec%0d_clean", k), 32'(clean_out), 32'(vecs[k].exp_clean));
      check($sformatf("vec%0d_changed", k), 32'(changed), 32'(vecs[k].exp_chg));
      check($sformatf("vec%0d_settled", k), 32'(settled), 32'(vecs[k].exp_settled));
    end

    // Chatter on bit 6: 2-cycle pulses never accepted, final hold accepted once.
    for (int t = 0; t < 5; t++) begin
      raw_in = 7'h40;
      step(2);
      raw_in = 7'h00;
      step(2);
    end
    check("chatter_clean", 32'(clean_out), 32'h0);
    raw_in = 7'h40;
    exp_q.push_back({7'h40, 7'h40});
    step(5);
    check("chatter_hold5_clean", 32'(clean_out), 32'h0);
    step(1);
    check("chatter_hold6_clean", 32'(clean_out), 32'h40);
    check("chatter_hold6_changed", 32'(changed), 32'h40);
    step(1);
    check("chatter_hold7_changed", 32'(changed), 32'h0);

    // Asynchronous reset mid-clock with all inputs high and counts pending.
    raw_in = 7'h7F;
    step(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clean", 32'(clean_out), 32'h0);
    check("async_rst_changed", 32'(changed), 32'h0);
    check("async_rst_settled", 32'(settled), 32'h0);
    raw_in = 7'h00;
    step(2);
    rst = 1'b0;
    step(2);
    check("refill_settled_low", 32'(settled), 32'h0);
    step(1);
    check("refill_settled_high", 32'(settled), 32'h1);
    check("refill_clean", 32'(clean_out), 32'h0);

    // Reset while cnt[1]==2: pending count is discarded, full latency after release.
    raw_in = 7'h02;
    step(4);
    check("midcount_pre_clean", 32'(clean_out), 32'h0);
    #1 rst = 1'b1;
    #1;
    check("midcount_rst_clean", 32'(clean_out), 32'h0);
    check("midcount_rst_changed", 32'(changed), 32'h0);
    #2 rst = 1'b0;
    exp_q.push_back({7'h02, 7'h02});
    step(5);
    check("midcount_edge5_clean", 32'(clean_out), 32'h0);
    step(1);
    check("midcount_edge6_clean", 32'(clean_out), 32'h02);
    check("midcount_edge6_changed", 32'(changed), 32'h02);
    step(1);
    check("midcount_edge7_changed", 32'(changed), 32'h0);

    step(3);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
